uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 p_data  input  DATA_WIDTH  parallel byte to transmit, sampled only on acceptance.
REQ-005 data_valid  input  1  p_data valid; a one-cycle pulse or a level.
REQ-006 par_en  input  1  1 = parity bit appended; sampled on acceptance.
REQ-007 par_typ  input  1  0 = even, 1 = odd; sampled on acceptance.
REQ-008 mux_sel  output  3  frame-field select for the downstream output mux: 000 start, 001 idle, 010 data, 011 parity, 100 stop.
REQ-009 ser_data  output  1  current serial data bit.
REQ-010 par_bit  output  1  parity bit of the accepted word.
REQ-011 busy  output  1  frame in progress.

Function
REQ-012 The FSM SHALL have exactly five states: IDLE, START, DATA, PARITY, STOP.
REQ-013 All outputs SHALL be registered or decoded from registered state only, with no combinational path from any input to any output.
REQ-014 In IDLE: mux_sel = 001 and busy = 0. ser_data and par_bit hold their last values.
REQ-015 Acceptance SHALL occur on a rising edge where state = IDLE and data_valid = 1. On that edge, p_data is latched into a shift register, and par_en and par_typ are latched.
REQ-016 On acceptance, par_bit SHALL be loaded with XOR-reduce(p_data) when par_typ = 0, and XNOR-reduce(p_data) when par_typ = 1.
REQ-017 For acceptance at edge N, the outputs SHALL be: START (mux_sel = 000, busy = 1) from edge N to N+1.
REQ-018 DATA SHALL follow START. mux_sel = 010 for exactly DATA_WIDTH cycles, from edge N+1 to N+1+DATA_WIDTH.
REQ-019 During DATA, ser_data SHALL present p_data bits LSB first. Bit k is valid between edges N+1+k and N+2+k; the shift register shifts right once per DATA cycle.
REQ-020 The DATA bit counter SHALL be ceil(log2(DATA_WIDTH))+1 bits wide, SHALL clear on entry to DATA, and SHALL exit DATA when the count reaches DATA_WIDTH-1.
REQ-021 When latched par_en = 1, PARITY SHALL follow DATA for one cycle with mux_sel = 011. When latched par_en = 0, PARITY SHALL be skipped.
REQ-022 STOP SHALL last one cycle with mux_sel = 100 and busy = 1. The next state is always IDLE.
REQ-023 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 only in IDLE.
REQ-024 data_valid, p_data, par_en and par_typ SHALL be ignored whenever state is not IDLE; no queuing occurs and the frame in flight is unaffected.
REQ-025 Back-to-back frames: with data_valid held at 1, the next acceptance SHALL occur on the first edge in IDLE. This gives exactly one IDLE cycle (mux_sel = 001) between STOP and the next START.
REQ-026 Frame length in cycles SHALL be DATA_WIDTH + 2 + par_en: 10 with parity disabled and 11 with parity enabled, at DATA_WIDTH = 8.
REQ-027 Changes to par_en or par_typ mid-frame SHALL NOT alter the current frame's parity presence or value.
REQ-028 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-029 When rst = 0, asynchronously: state = IDLE, mux_sel = 001, busy = 0, ser_data = 0, par_bit = 0, and the shift register, counter and latched configuration are all 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, with no partial completion.
REQ-031 After reset deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-032 Reset: assert rst = 0 mid-DATA -> mux_sel = 001 and busy = 0 immediately, without waiting for clk; ser_data = 0 and par_bit = 0.
REQ-033 Basic no parity: p_data = 0xA5, par_en = 0, single-cycle data_valid -> mux_sel sequence 000, 010 x8, 100, 001. ser_data = 1,0,1,0,0,1,0,1. busy high for 10 cycles.
REQ-034 Even parity: p_data = 0x07, par_en = 1, par_typ = 0 -> PARITY cycle present with par_bit = 1 and busy high for 11 cycles. Repeat with par_typ = 1 -> par_bit = 0.
REQ-035 Ignored input: pulse data_valid with p_data = 0xFF during DATA of a 0x00 frame -> the frame sends eight 0 bits; no second frame follows.
REQ-036 Back-to-back: data_valid held high with 0x3C then 0xC3, par_en = 1 -> exactly one IDLE cycle between STOP and START. Second frame bits are LSB first and correct; par_bit = 0 for both frames (even parity).
REQ-037 Config change: toggle par_en 1 -> 0 during DATA -> the current frame still includes PARITY; the next frame omits it.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: walks START, DATA (LSB first), optional PARITY and STOP,
// driving the downstream field-select mux, the serial data bit and the frame parity bit.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [2:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  ser_data_q, ser_data_d;
    logic                  par_bit_q, par_bit_d;
    logic                  accept_s;
    logic                  last_bit_s;

    // par_typ=0 gives even parity (XOR-reduce), par_typ=1 gives odd parity (XNOR-reduce)
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return odd ? ~(^d) : (^d);
    endfunction

    assign accept_s   = (state_q == IDLE) && data_valid;
    assign last_bit_s = (cnt_q == CNT_W'(DATA_WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; any unused encoding falls back to IDLE
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = accept_s ? START : IDLE;
            START:   state_d = DATA;
            DATA: begin
                if (last_bit_s) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    state_d = DATA;
                end
            end
            PARITY:  state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        mux_sel = 3'b001;
        busy    = 1'b1;
        case (state_q)
            IDLE: begin
                mux_sel = 3'b001;
                busy    = 1'b0;
            end
            START:   mux_sel = 3'b000;
            DATA:    mux_sel = 3'b010;
            PARITY:  mux_sel = 3'b011;
            STOP:    mux_sel = 3'b100;
            default: begin
                mux_sel = 3'b001;
                busy    = 1'b0;
            end
        endcase
    end

    // Datapath next values: the odd/even choice is folded into par_bit at acceptance,
    // so only par_en needs its own latch to steer the frame after DATA
    always_comb begin
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        ser_data_d = ser_data_q;
        par_bit_d  = par_bit_q;
        cnt_d      = cnt_q;
        if (accept_s) begin
            shift_d   = p_data;
            par_en_d  = par_en;
            par_bit_d = calc_parity(p_data, par_typ);
        end else if (state_d == DATA) begin
            // load bit k on the edge that opens DATA cycle k, so ser_data is registered
            ser_data_d = shift_q[0];
            shift_d    = shift_q >> 1;
        end else begin
            shift_d = shift_q;
        end
        if (state_q == START) begin
            cnt_d = '0;
        end else if (state_q == DATA) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            par_en_q   <= 1'b0;
            ser_data_q <= 1'b0;
            par_bit_q  <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            par_en_q   <= par_en_d;
            ser_data_q <= ser_data_d;
            par_bit_q  <= par_bit_d;
        end
    end

    assign ser_data = ser_data_q;
    assign par_bit  = par_bit_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed frame scenarios plus randomized frames
// compared against a cycle-list model of the expected frame.
module tb_uart_tx_ctrl;

    localparam int W = 8;
    localparam logic [2:0] M_START = 3'b000;
    localparam logic [2:0] M_IDLE  = 3'b001;
    localparam logic [2:0] M_DATA  = 3'b010;
    localparam logic [2:0] M_PAR   = 3'b011;
    localparam logic [2:0] M_STOP  = 3'b100;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] p_data;
    logic         data_valid;
    logic         par_en;
    logic         par_typ;
    logic [2:0]   mux_sel;
    logic         ser_data;
    logic         par_bit;
    logic         busy;

    int errors = 0;
    int checks = 0;

    logic [2:0] em[$];
    logic       es[$];
    bit         ev[$];
    logic       ep;

    uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .mux_sel    (mux_sel),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected frame as a per-cycle list, starting with the cycle after the accepting edge
    function automatic void build(input logic [W-1:0] d, input bit en, input bit typ);
        int ones;
        em.delete(); es.delete(); ev.delete();
        ones = 0;
        for (int i = 0; i < W; i++) ones += int'(d[i]);
        ep = typ ? ((ones % 2) == 0) : ((ones % 2) == 1);
        em.push_back(M_START); es.push_back(1'b0); ev.push_back(1'b0);
        for (int i = 0; i < W; i++) begin
            em.push_back(M_DATA); es.push_back(d[i]); ev.push_back(1'b1);
        end
        if (en) begin
            em.push_back(M_PAR); es.push_back(1'b0); ev.push_back(1'b0);
        end
        em.push_back(M_STOP); es.push_back(1'b0); ev.push_back(1'b0);
    endfunction

    task automatic test_reset();
        rst = 1'b1; data_valid = 1'b0; p_data = '0; par_en = 1'b0; par_typ = 1'b0;
        #1 rst = 1'b0;
        #2;
        checks += 4;
        if (mux_sel !== M_IDLE) begin errors++; $display("FAIL reset_mux got=%b exp=%b", mux_sel, M_IDLE); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (ser_data !== 1'b0) begin errors++; $display("FAIL reset_ser got=%b exp=0", ser_data); end
        if (par_bit !== 1'b0) begin errors++; $display("FAIL reset_par got=%b exp=0", par_bit); end
        // first edge after release accepts
        p_data = 8'h07; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
        @(negedge clk) rst = 1'b1;
        tick();
        data_valid = 1'b0;
        checks++;
        if (mux_sel !== M_START) begin errors++; $display("FAIL reset_first_accept got=%b exp=%b", mux_sel, M_START); end
        tick(); tick();
        checks += 3;
        if (mux_sel !== M_DATA) begin errors++; $display("FAIL reset_pre_mux got=%b exp=%b", mux_sel, M_DATA); end
        if (ser_data !== 1'b1) begin errors++; $display("FAIL reset_pre_ser got=%b exp=1", ser_data); end
        if (par_bit !== 1'b1) begin errors++; $display("FAIL reset_pre_par got=%b exp=1", par_bit); end
        // async abort mid-DATA, observed before the next clock edge
        #2 rst = 1'b0;
        #1;
        checks += 4;
        if (mux_sel !== M_IDLE) begin errors++; $display("FAIL abort_mux got=%b exp=%b", mux_sel, M_IDLE); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        if (ser_data !== 1'b0) begin errors++; $display("FAIL abort_ser got=%b exp=0", ser_data); end
        if (par_bit !== 1'b0) begin errors++; $display("FAIL abort_par got=%b exp=0", par_bit); end
        @(negedge clk) rst = 1'b1;
        tick(); tick();
        checks += 2;
        if (mux_sel !== M_IDLE) begin errors++; $display("FAIL abort_resume_mux got=%b exp=%b", mux_sel, M_IDLE); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_resume_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        int bcnt;
        bcnt = 0;
        p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        build(8'hA5, 1'b0, 1'b0);
        for (int c = 0; c < em.size(); c++) begin
            tick();
            if (c == 0) data_valid = 1'b0;
            if (busy === 1'b1) bcnt++;
            checks += 2;
            if (mux_sel !== em[c]) begin errors++; $display("FAIL basic_mux c=%0d got=%b exp=%b", c, mux_sel, em[c]); end
            if (par_bit !== ep) begin errors++; $display("FAIL basic_par c=%0d got=%b exp=%b", c, par_bit, ep); end
            if (ev[c]) begin
                checks++;
                if (ser_data !== es[c]) begin errors++; $display("FAIL basic_ser c=%0d got=%b exp=%b", c, ser_data, es[c]); end
            end
        end
        tick();
        checks += 3;
        if (mux_sel !== M_IDLE) begin errors++; $display("FAIL basic_idle got=%b exp=%b", mux_sel, M_IDLE); end
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
        if (bcnt != 10) begin errors++; $display("FAIL basic_busy_len got=%0d exp=10", bcnt); end
    endtask

    task automatic test_parity();
        for (int t = 0; t < 2; t++) begin
            p_data = 8'h07; par_en = 1'b1; par_typ = t[0]; data_valid = 1'b1;
            build(8'h07, 1'b1, t[0]);
            checks++;
            if (ep !== ~t[0]) begin errors++; $display("FAIL parity_model typ=%0d got=%b exp=%b", t, ep, ~t[0]); end
            for (int c = 0; c < em.size(); c++) begin
                tick();
                if (c == 0) data_valid = 1'b0;
                checks += 3;
                if (mux_sel !== em[c]) begin errors++; $display("FAIL parity_mux typ=%0d c=%0d got=%b exp=%b", t, c, mux_sel, em[c]); end
                if (busy !== 1'b1) begin errors++; $display("FAIL parity_busy typ=%0d c=%0d got=%b exp=1", t, c, busy); end
                if (par_bit !== ep) begin errors++; $display("FAIL parity_bit typ=%0d c=%0d got=%b exp=%b", t, c, par_bit, ep); end
            end
            tick();
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL parity_end_busy typ=%0d got=%b exp=0", t, busy); end
        end
    endtask

    task automatic test_ignored();
        p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        build(8'h00, 1'b0, 1'b0);
        for (int c = 0; c < em.size(); c++) begin
            tick();
            if (c == 0) data_valid = 1'b0;
            if (c == 3) begin data_valid = 1'b1; p_data = 8'hFF; end
            if (c == 4) data_valid = 1'b0;
            checks++;
            if (mux_sel !== em[c]) begin errors++; $display("FAIL ignored_mux c=%0d got=%b exp=%b", c, mux_sel, em[c]); end
            if (ev[c]) begin
                checks++;
                if (ser_data !== es[c]) begin errors++; $display("FAIL ignored_ser c=%0d got=%b exp=%b", c, ser_data, es[c]); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 2;
            if (mux_sel !== M_IDLE) begin errors++; $display("FAIL ignored_idle i=%0d got=%b exp=%b", i, mux_sel, M_IDLE); end
            if (busy !== 1'b0) begin errors++; $display("FAIL ignored_busy i=%0d got=%b exp=0", i, busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [2];
        words[0] = 8'h3C; words[1] = 8'hC3;
        p_data = words[0]; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
        for (int f = 0; f < 2; f++) begin
            build(words[f], 1'b1, 1'b0);
            for (int c = 0; c < em.size(); c++) begin
                tick();
                if (c == 0) begin
                    p_data = words[1];
                    if (f == 1) data_valid = 1'b0;
                end
                checks += 2;
                if (mux_sel !== em[c]) begin errors++; $display("FAIL b2b_mux f=%0d c=%0d got=%b exp=%b", f, c, mux_sel, em[c]); end
                if (par_bit !== ep) begin errors++; $display("FAIL b2b_par f=%0d c=%0d got=%b exp=%b", f, c, par_bit, ep); end
                if (ev[c]) begin
                    checks++;
                    if (ser_data !== es[c]) begin errors++; $display("FAIL b2b_ser f=%0d c=%0d got=%b exp=%b", f, c, ser_data, es[c]); end
                end
            end
            tick();
            checks += 2;
            if (mux_sel !== M_IDLE) begin errors++; $display("FAIL b2b_gap f=%0d got=%b exp=%b", f, mux_sel, M_IDLE); end
            if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy f=%0d got=%b exp=0", f, busy); end
        end
        tick();
        checks++;
        if (mux_sel !== M_IDLE) begin errors++; $display("FAIL b2b_tail got=%b exp=%b", mux_sel, M_IDLE); end
    endtask

    task automatic test_config_change();
        bit en;
        en = 1'b1;
        p_data = 8'h96; par_en = 1'b1; par_typ = 1'b1; data_valid = 1'b1;
        for (int f = 0; f < 2; f++) begin
            build(8'h96, en, 1'b1 & en);
            for (int c = 0; c < em.size(); c++) begin
                tick();
                if (c == 0) data_valid = 1'b0;
                if (c == 2) begin par_en = 1'b0; par_typ = 1'b0; end
                checks += 2;
                if (mux_sel !== em[c]) begin errors++; $display("FAIL cfg_mux f=%0d c=%0d got=%b exp=%b", f, c, mux_sel, em[c]); end
                if (par_bit !== ep) begin errors++; $display("FAIL cfg_par f=%0d c=%0d got=%b exp=%b", f, c, par_bit, ep); end
            end
            tick();
            checks++;
            if (mux_sel !== M_IDLE) begin errors++; $display("FAIL cfg_idle f=%0d got=%b exp=%b", f, mux_sel, M_IDLE); end
            en = 1'b0;
            data_valid = 1'b1;
        end
        data_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        bit           en, typ;
        for (int f = 0; f < 20; f++) begin
            d = W'($urandom); en = 1'($urandom); typ = 1'($urandom);
            p_data = d; par_en = en; par_typ = typ; data_valid = 1'b1;
            build(d, en, typ);
            for (int c = 0; c < em.size(); c++) begin
                tick();
                if (c == em.size() - 1) begin
                    data_valid = 1'b0;
                end else begin
                    data_valid = 1'($urandom); p_data = W'($urandom);
                    par_en = 1'($urandom); par_typ = 1'($urandom);
                end
                checks += 3;
                if (mux_sel !== em[c]) begin errors++; $display("FAIL rand_mux f=%0d c=%0d got=%b exp=%b", f, c, mux_sel, em[c]); end
                if (busy !== 1'b1) begin errors++; $display("FAIL rand_busy f=%0d c=%0d got=%b exp=1", f, c, busy); end
                if (par_bit !== ep) begin errors++; $display("FAIL rand_par f=%0d c=%0d got=%b exp=%b", f, c, par_bit, ep); end
                if (ev[c]) begin
                    checks++;
                    if (ser_data !== es[c]) begin errors++; $display("FAIL rand_ser f=%0d c=%0d got=%b exp=%b", f, c, ser_data, es[c]); end
                end
            end
            tick();
            checks += 3;
            if (mux_sel !== M_IDLE) begin errors++; $display("FAIL rand_idle f=%0d got=%b exp=%b", f, mux_sel, M_IDLE); end
            if (busy !== 1'b0) begin errors++; $display("FAIL rand_idle_busy f=%0d got=%b exp=0", f, busy); end
            if (ser_data !== d[W-1]) begin errors++; $display("FAIL rand_idle_ser f=%0d got=%b exp=%b", f, ser_data, d[W-1]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_ignored();
        test_back_to_back();
        test_config_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
